bf_relax_pe_pipe: RTL

- Pipelined, parametrised Bellman-Ford edge-relaxation element for the bf16x16 fabric.
- Takes a source distance and a packed target node word {pred, weight, dist}, and produces the relaxed target word.
- Generalised field widths, explicit infinity and saturation handling, valid/ready flow control, and a sticky per-pass "dirty" flag the scheduler uses for early termination.
- Sits between the node-memory read port and the write-back arbiter.

---
 rtl/bf_relax_pe_pipe.sv | 113 +++++++++++
 1 files changed

// File: rtl/bf_relax_pe_pipe.sv
// Two-stage Bellman-Ford edge-relaxation element with valid/ready flow control and a sticky pass-dirty flag.
// Optional build macro BF_PE_UPD_COUNT_EN adds a saturating 16-bit upd_count of updating beats.
module bf_relax_pe_pipe #(
  parameter int PW = 3,
  parameter int WW = 8,
  parameter int DW = 21,
  localparam int NW = PW + WW + DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_src_id,
  input  logic [DW-1:0] in_src_dist,
  input  logic [NW-1:0] in_t,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] out_t,
  output logic          out_updated,
  input  logic          pass_clr,
  output logic          pass_dirty
`ifdef BF_PE_UPD_COUNT_EN
  ,
  output logic [15:0]   upd_count
`endif
);

  localparam logic [DW-1:0] INF = '1;

  logic [WW-1:0] weight;
  logic [DW-1:0] tgtDist;
  logic [DW:0]   sum;
  logic          candInf;
  logic [DW-1:0] cand;
  logic          upd;
  logic [NW-1:0] relaxed;

  logic          s1Valid;
  logic [NW-1:0] s1T;
  logic          s1Upd;

  logic          s2Adv;
  logic          s1Adv;
  logic          updXfer;

  assign weight  = in_t[DW+WW-1:DW];
  assign tgtDist = in_t[DW-1:0];

  // One extra bit keeps the carry so overflow saturates to INF instead of wrapping.
  assign sum     = {1'b0, in_src_dist} + {{(DW+1-WW){1'b0}}, weight};
  assign candInf = (in_src_dist == INF) || sum[DW] || (sum[DW-1:0] == INF);
  assign cand    = candInf ? INF : sum[DW-1:0];
  assign upd     = (cand < tgtDist);
  assign relaxed = upd ? {in_src_id, weight, cand} : in_t;

  assign s2Adv    = !out_valid || out_ready;
  assign s1Adv    = !s1Valid || s2Adv;
  assign in_ready = s1Adv;
  assign updXfer  = out_valid && out_ready && out_updated;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1T     <= '0;
      s1Upd   <= 1'b0;
    end else if (s1Adv) begin
      s1Valid <= in_valid;
      if (in_valid) begin
        s1T   <= relaxed;
        s1Upd <= upd;
      end
    end
  end

  // Payload only reloads on a real beat, so a bubble leaves the last word parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_t       <= '0;
      out_updated <= 1'b0;
    end else if (s2Adv) begin
      out_valid <= s1Valid;
      if (s1Valid) begin
        out_t       <= s1T;
        out_updated <= s1Upd;
      end else begin
        out_updated <= 1'b0;
      end
    end
  end

  // An updating transfer outranks a simultaneous clear so no update is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_dirty <= 1'b0;
    end else if (updXfer) begin
      pass_dirty <= 1'b1;
    end else if (pass_clr) begin
      pass_dirty <= 1'b0;
    end
  end

`ifdef BF_PE_UPD_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || pass_clr) begin
      upd_count <= '0;
    end else if (updXfer && (upd_count != 16'hFFFF)) begin
      upd_count <= upd_count + 16'd1;
    end
  end
`endif

endmodule
